// File: rtl/uart_alu_if.sv
// uart_alu_if: pulls operand A, operand B and opcode bytes from the uart rx FIFO, drives them to an
// external ALU and pushes the ALU result into the tx FIFO. Optional inter-byte timeout: UART_IF_TIMEOUT_EN.
module uart_alu_if #(
  parameter int DBIT           = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TO_BIT         = 21
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_rx_empty,
  input  logic [DBIT-1:0]  i_r_data,
  output logic             o_rd_uart,
  input  logic             i_tx_full,
  output logic             o_wr_uart,
  output logic [DBIT-1:0]  o_w_data,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_opcode,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic             o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    COMPUTE = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             rd_s;
  logic             wr_s;
  logic             expire_s;
  logic [DBIT-1:0]  data_a_r;
  logic [DBIT-1:0]  data_b_r;
  logic [DBIT-1:0]  result_r;
  logic [NB_OP-1:0] opcode_r;

`ifdef UART_IF_TIMEOUT_EN
  logic [TO_BIT-1:0] to_cnt_r;
  logic              waiting_s;

  // A byte present in the expiry cycle wins, so expiry requires an empty rx FIFO.
  assign waiting_s = (state_r == WAIT_B) || (state_r == WAIT_OP);
  assign expire_s  = waiting_s && i_rx_empty && (to_cnt_r == TO_BIT'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter, running only while a frame is partially received.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      to_cnt_r <= {TO_BIT{1'b0}};
    end else if (waiting_s && i_rx_empty && !expire_s) begin
      to_cnt_r <= to_cnt_r + {{(TO_BIT-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_r <= {TO_BIT{1'b0}};
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and strobe decode; strobes are combinational so a pop lands in the consuming cycle.
  always_comb begin
    state_s = state_r;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    case (state_r)
      WAIT_A: begin
        if (!i_rx_empty) begin
          rd_s    = 1'b1;
          state_s = WAIT_B;
        end else begin
          state_s = WAIT_A;
        end
      end
      WAIT_B: begin
        if (!i_rx_empty) begin
          rd_s    = 1'b1;
          state_s = WAIT_OP;
        end else if (expire_s) begin
          state_s = WAIT_A;
        end else begin
          state_s = WAIT_B;
        end
      end
      WAIT_OP: begin
        if (!i_rx_empty) begin
          rd_s    = 1'b1;
          state_s = COMPUTE;
        end else if (expire_s) begin
          state_s = WAIT_A;
        end else begin
          state_s = WAIT_OP;
        end
      end
      COMPUTE: begin
        state_s = SEND;
      end
      SEND: begin
        if (!i_tx_full) begin
          wr_s    = 1'b1;
          state_s = WAIT_A;
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = WAIT_A;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= WAIT_A;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand, opcode and result capture; operands persist until the next frame overwrites them.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      data_a_r <= {DBIT{1'b0}};
      data_b_r <= {DBIT{1'b0}};
      opcode_r <= {NB_OP{1'b0}};
      result_r <= {DBIT{1'b0}};
    end else begin
      if (rd_s && (state_r == WAIT_A)) begin
        data_a_r <= i_r_data;
      end
      if (rd_s && (state_r == WAIT_B)) begin
        data_b_r <= i_r_data;
      end
      if (rd_s && (state_r == WAIT_OP)) begin
        opcode_r <= i_r_data[NB_OP-1:0];
      end
      if (state_r == COMPUTE) begin
        result_r <= i_alu_result;
      end
    end
  end

  assign o_rd_uart = rd_s;
  assign o_wr_uart = wr_s;
  assign o_w_data  = result_r;
  assign o_data_a  = data_a_r;
  assign o_data_b  = data_b_r;
  assign o_opcode  = opcode_r;
  assign o_timeout = expire_s;

endmodule

// File: tb/tb_uart_alu_if.sv
// Bench for uart_alu_if: a byte-stream model predicts pops, pushes, operands and results cycle by cycle.
module tb_uart_alu_if;
  localparam int DBIT  = 8;
  localparam int NB_OP = 6;
`ifdef UART_IF_TIMEOUT_EN
  localparam int TO_CYC = 50;
`else
  localparam int TO_CYC = 2000000;
`endif

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_rx_empty;
  logic [DBIT-1:0]  i_r_data;
  logic             o_rd_uart;
  logic             i_tx_full;
  logic             o_wr_uart;
  logic [DBIT-1:0]  o_w_data;
  logic [DBIT-1:0]  o_data_a;
  logic [DBIT-1:0]  o_data_b;
  logic [NB_OP-1:0] o_opcode;
  logic [DBIT-1:0]  i_alu_result;
  logic             o_timeout;

  uart_alu_if #(.DBIT(DBIT), .NB_OP(NB_OP), .TIMEOUT_CYCLES(TO_CYC), .TO_BIT(21)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_empty(i_rx_empty), .i_r_data(i_r_data),
    .o_rd_uart(o_rd_uart), .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_opcode(o_opcode),
    .i_alu_result(i_alu_result), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return 8'(a + b);
      6'h22:   return 8'(a - b);
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  // External ALU stand-in.
  always_comb i_alu_result = alu_ref(o_data_a, o_data_b, o_opcode);

  logic [7:0] rxq[$];
  logic [7:0] frame[$];
  logic [7:0] exp_val[$];
  int         exp_due[$];
  logic [7:0] exp_a, exp_b, last_wdata;
  logic [5:0] exp_op;
  int cyc, idle, gap_pct, full_pct;
  int n_checks, n_fail, n_rd, n_wr, n_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic gap, busy, exp_rd, exp_wr, exp_to;
    gap        = (gap_pct > 0) && ($urandom_range(99) < gap_pct);
    i_rx_empty = gap || (rxq.size() == 0);
    i_r_data   = (rxq.size() != 0) ? rxq[0] : 8'($urandom);
    if (full_pct > 0) i_tx_full = ($urandom_range(99) < full_pct);
    #1;
    busy   = (exp_val.size() != 0);
    exp_rd = i_reset && !i_rx_empty && !busy;
    exp_wr = i_reset && busy && (cyc >= exp_due[0]) && !i_tx_full;
    exp_to = 1'b0;
`ifdef UART_IF_TIMEOUT_EN
    exp_to = i_reset && (frame.size() != 0) && i_rx_empty && (idle == TO_CYC - 1);
`endif
    chk("rd_strobe", o_rd_uart, exp_rd);
    chk("wr_strobe", o_wr_uart, exp_wr);
    chk("timeout", o_timeout, exp_to);
    chk("data_a", o_data_a, exp_a);
    chk("data_b", o_data_b, exp_b);
    chk("opcode", o_opcode, exp_op);
    if (busy && cyc >= exp_due[0]) chk("w_data", o_w_data, exp_val[0]);
    if (o_rd_uart) n_rd++;
    if (o_timeout) n_to++;
    if (o_wr_uart) begin
      n_wr++;
      last_wdata = o_w_data;
    end
    @(posedge i_clk);
    if (i_reset) begin
      if (exp_rd) begin
        frame.push_back(rxq.pop_front());
        idle = 0;
        if (frame.size() == 1) exp_a = frame[0];
        if (frame.size() == 2) exp_b = frame[1];
        if (frame.size() == 3) begin
          exp_op = frame[2][5:0];
          exp_val.push_back(alu_ref(frame[0], frame[1], frame[2][5:0]));
          exp_due.push_back(cyc + 2);
          frame.delete();
        end
      end else if (exp_to) begin
        frame.delete();
        idle = 0;
      end else if (frame.size() != 0) begin
        idle++;
      end
      if (exp_wr) begin
        void'(exp_val.pop_front());
        void'(exp_due.pop_front());
      end
    end
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic apply_reset(input int n);
    i_reset = 1'b0;
    rxq.delete(); frame.delete(); exp_val.delete(); exp_due.delete();
    exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00; idle = 0;
    repeat (n) tick();
    i_reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 600 && (rxq.size() != 0 || exp_val.size() != 0); i++) tick();
    chk(tag, rxq.size() + exp_val.size(), 0);
  endtask

  function automatic logic [7:0] rand_op();
    logic [5:0] ops[6];
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    return {2'($urandom), ops[$urandom_range(5)]};
  endfunction

  initial begin
    int rd0, wr0, to0;
    n_checks = 0; n_fail = 0; n_rd = 0; n_wr = 0; n_to = 0; cyc = 0;
    gap_pct = 0; full_pct = 0; i_tx_full = 1'b0; i_rx_empty = 1'b1; i_r_data = 8'h00;
    last_wdata = 8'h00;
    @(negedge i_clk);
    apply_reset(3);
    // Idle after reset: no strobes, all outputs zero.
    repeat (20) tick();
    chk("idle_rd_count", n_rd, 0);
    chk("idle_wr_count", n_wr, 0);
    chk("reset_w_data", o_w_data, 8'h00);

    // Directed frame with gaps: 5 + 3.
    rd0 = n_rd; wr0 = n_wr;
    gap_pct = 50;
    rxq.push_back(8'h05); rxq.push_back(8'h03); rxq.push_back(8'hE0);
    drain("t2_drain");
    chk("t2_rd_count", n_rd - rd0, 3);
    chk("t2_wr_count", n_wr - wr0, 1);
    chk("t2_a", o_data_a, 8'h05);
    chk("t2_b", o_data_b, 8'h03);
    chk("t2_op", o_opcode, 6'h20);
    chk("t2_wdata", last_wdata, 8'h08);

    // Two back-to-back frames with no gaps.
    rd0 = n_rd; wr0 = n_wr; gap_pct = 0;
    for (int i = 0; i < 6; i++) rxq.push_back((i % 3 == 2) ? rand_op() : 8'($urandom));
    drain("t3_drain");
    chk("t3_rd_count", n_rd - rd0, 6);
    chk("t3_wr_count", n_wr - wr0, 2);

    // tx FIFO full for 10 cycles on entering SEND while rx still holds a frame.
    rd0 = n_rd; wr0 = n_wr;
    for (int i = 0; i < 6; i++) rxq.push_back((i % 3 == 2) ? rand_op() : 8'($urandom));
    for (int i = 0; i < 20 && !(exp_val.size() != 0 && cyc >= exp_due[0]); i++) tick();
    i_tx_full = 1'b1;
    repeat (10) tick();
    chk("t4_stall_wr", n_wr - wr0, 0);
    chk("t4_stall_rd", n_rd - rd0, 3);
    i_tx_full = 1'b0;
    drain("t4_drain");
    chk("t4_wr_count", n_wr - wr0, 2);

    // Reset mid-frame discards operand A = 0x11.
    wr0 = n_wr;
    rxq.push_back(8'h11);
    for (int i = 0; i < 10 && rxq.size() != 0; i++) tick();
    apply_reset(2);
    rxq.push_back(8'h02); rxq.push_back(8'h04); rxq.push_back(8'hE2);
    drain("t5_drain");
    chk("t5_a", o_data_a, 8'h02);
    chk("t5_b", o_data_b, 8'h04);
    chk("t5_wdata", last_wdata, 8'hFE);
    chk("t5_wr_count", n_wr - wr0, 1);

    // Random frames with random rx gaps and tx back-pressure.
    gap_pct = 30; full_pct = 30;
    for (int f = 0; f < 20; f++) begin
      rxq.push_back(8'($urandom)); rxq.push_back(8'($urandom)); rxq.push_back(rand_op());
      if ($urandom_range(1) == 1) drain("rand_drain");
    end
    drain("rand_final_drain");
    gap_pct = 0; full_pct = 0; i_tx_full = 1'b0;

`ifdef UART_IF_TIMEOUT_EN
    // Timeout after operand A only, then a normal frame.
    to0 = n_to; wr0 = n_wr;
    rxq.push_back(8'h33);
    for (int i = 0; i < 10 && rxq.size() != 0; i++) tick();
    repeat (TO_CYC + 10) tick();
    chk("t6_timeout_count", n_to - to0, 1);
    rxq.push_back(8'h07); rxq.push_back(8'h09); rxq.push_back(8'h20);
    drain("t6_drain");
    chk("t6_wdata", last_wdata, 8'h10);
    chk("t6_wr_count", n_wr - wr0, 1);
    // Byte arriving in the expiry cycle wins.
    to0 = n_to;
    rxq.push_back(8'h01);
    for (int i = 0; i < 10 && rxq.size() != 0; i++) tick();
    for (int i = 0; i < 2 * TO_CYC && idle < TO_CYC - 1; i++) tick();
    rxq.push_back(8'h02); rxq.push_back(8'h20);
    drain("t6b_drain");
    chk("t6b_timeout_count", n_to - to0, 0);
    chk("t6b_wdata", last_wdata, 8'h03);
`else
    to0 = n_to;
    repeat (5) tick();
    chk("no_timeout_count", n_to - to0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
